// File: rtl/ula_controle_multiciclo.sv
// Multicycle MIPS main control unit: sequences fetch/decode/execute,
// drives the datapath enables and mux selects, produces the ALU
// operation and carry-in for the shared ULA, and counts retired
// instructions.
module ula_controle_multiciclo #(
  parameter int unsigned CONT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  output logic              pc_en,
  output logic              iord,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              ula_src_a,
  output logic [1:0]        ula_src_b,
  output logic [1:0]        pc_src,
  output logic [2:0]        ULAcontrole,
  output logic              ula_cin,
  output logic [3:0]        estado,
  output logic [CONT_W-1:0] instr_count
);

  // Opcodes recognised in DECODE / MEMADR
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ULA operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Internal ALU-op class driven by the FSM
  localparam logic [1:0] ULAOP_ADD   = 2'b00;
  localparam logic [1:0] ULAOP_SUB   = 2'b01;
  localparam logic [1:0] ULAOP_FUNCT = 2'b10;

  // Mux select encodings
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ULA   = 2'b00;
  localparam logic [1:0] PCSRC_OUT   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t              r_state;
  state_t              w_next;
  state_t              w_dec_state;
  logic                w_retire;
  logic [CONT_W-1:0]   r_count;
  logic                w_pc_write;
  logic                w_branch;
  logic                w_ir_write;
  logic                w_mem_write;
  logic                w_reg_write;
  logic [1:0]          w_ula_op;

  // Next-state selection; illegal encodings fall back to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:    w_next = S_MEMADR;
          OP_RTYPE: w_next = S_EXECUTE;
          OP_BEQ:   w_next = S_BRANCH;
          OP_ADDI:  w_next = S_ADDIEX;
          OP_J:     w_next = S_JUMP;
          default:  w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // An instruction retires on leaving its last state, or DECODE for a NOP opcode
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_MEMWRITE, S_ALUWB,
      S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
      S_DECODE:                   w_retire = (w_next == S_FETCH);
      default:                    w_retire = 1'b0;
    endcase
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_count <= r_count + CONT_W'(1);
      end
    end
  end

  // Moore output decode; reset shows FETCH values with writes suppressed
  always_comb begin
    w_dec_state = rst ? S_FETCH : r_state;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_ula_op    = ULAOP_ADD;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    ula_src_a   = 1'b0;
    ula_src_b   = SRCB_B;
    pc_src      = PCSRC_ULA;
    case (w_dec_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        ula_src_b  = SRCB_FOUR;
      end
      S_DECODE: begin
        ula_src_b = SRCB_IMM_SH;
      end
      S_MEMADR, S_ADDIEX: begin
        ula_src_a = 1'b1;
        ula_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWRITE: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ula_src_a = 1'b1;
        w_ula_op  = ULAOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        ula_src_a = 1'b1;
        w_ula_op  = ULAOP_SUB;
        pc_src    = PCSRC_OUT;
        w_branch  = 1'b1;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: begin
      end
    endcase

    ULAcontrole = ALU_ADD;
    ula_cin     = 1'b0;
    case (w_ula_op)
      ULAOP_SUB: begin
        ULAcontrole = ALU_SUB;
        ula_cin     = 1'b1;
      end
      ULAOP_FUNCT: begin
        case (funct)
          FN_SUB: begin
            ULAcontrole = ALU_SUB;
            ula_cin     = 1'b1;
          end
          FN_AND:  ULAcontrole = ALU_AND;
          FN_OR:   ULAcontrole = ALU_OR;
          FN_SLT: begin
            ULAcontrole = ALU_SLT;
            ula_cin     = 1'b1;
          end
          FN_ADD:  ULAcontrole = ALU_ADD;
          default: ULAcontrole = ALU_ADD;
        endcase
      end
      default: begin
      end
    endcase

    pc_en     = ~rst & (w_pc_write | (w_branch & zero));
    ir_write  = ~rst & w_ir_write;
    mem_write = ~rst & w_mem_write;
    reg_write = ~rst & w_reg_write;
    estado    = w_dec_state;
  end

  assign instr_count = r_count;

endmodule

// File: tb/tb_ula_controle_multiciclo.sv
// Self-checking bench for ula_controle_multiciclo: a reference model
// pushes expected per-cycle outputs to a scoreboard which is popped and
// compared against the DUT on the falling edge.
module tb_ula_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic        pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, ula_src_a;
  logic [1:0]  ula_src_b, pc_src;
  logic [2:0]  alu_ctl;
  logic        ula_cin;
  logic [3:0]  estado;
  logic [31:0] instr_count;

  logic        d4_pc_en, d4_iord, d4_mem_write, d4_ir_write, d4_reg_dst, d4_mem_to_reg;
  logic        d4_reg_write, d4_ula_src_a;
  logic [1:0]  d4_ula_src_b, d4_pc_src;
  logic [2:0]  d4_alu_ctl;
  logic        d4_ula_cin;
  logic [3:0]  d4_estado;
  logic [3:0]  d4_instr_count;

  always #5 clk = ~clk;

  ula_controle_multiciclo u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .ula_src_a(ula_src_a), .ula_src_b(ula_src_b), .pc_src(pc_src),
    .ULAcontrole(alu_ctl), .ula_cin(ula_cin), .estado(estado),
    .instr_count(instr_count)
  );

  ula_controle_multiciclo #(.CONT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(d4_pc_en), .iord(d4_iord), .mem_write(d4_mem_write), .ir_write(d4_ir_write),
    .reg_dst(d4_reg_dst), .mem_to_reg(d4_mem_to_reg), .reg_write(d4_reg_write),
    .ula_src_a(d4_ula_src_a), .ula_src_b(d4_ula_src_b), .pc_src(d4_pc_src),
    .ULAcontrole(d4_alu_ctl), .ula_cin(d4_ula_cin), .estado(d4_estado),
    .instr_count(d4_instr_count)
  );

  typedef struct packed {
    logic [3:0]  estado;
    logic [15:0] ctrl;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    logic        chk_cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_state;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_next(input int s, input logic [5:0] op);
    case (s)
      0: return 1;
      1: begin
        case (op)
          6'b100011, 6'b101011: return 2;
          6'b000000: return 6;
          6'b000100: return 8;
          6'b001000: return 9;
          6'b000010: return 11;
          default:   return 0;
        endcase
      end
      2: return (op == 6'b101011) ? 5 : 3;
      3: return 4;
      6: return 7;
      9: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_retire(input int s, input logic [5:0] op);
    if (s == 4 || s == 5 || s == 7 || s == 8 || s == 10 || s == 11) return 1'b1;
    if (s == 1 && m_next(1, op) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, ula_src_a,
  //  ula_src_b, pc_src, ULAcontrole, ula_cin}
  function automatic logic [15:0] exp_ctrl(input int s, input logic [5:0] fn,
                                           input logic z, input logic r);
    logic pcw, br, io, mw, ir, rd, mtr, rw, sa;
    logic [1:0] sb, ps, op;
    logic [2:0] ac;
    logic cin, pe;
    int st;
    pcw = 0; br = 0; io = 0; mw = 0; ir = 0; rd = 0; mtr = 0; rw = 0; sa = 0;
    sb = 2'b00; ps = 2'b00; op = 2'b00;
    st = r ? 0 : s;
    case (st)
      0:  begin ir = 1; pcw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2, 9: begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; mtr = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 2'b01; ps = 2'b01; br = 1; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    ac = 3'b010; cin = 0;
    if (op == 2'b01) begin ac = 3'b110; cin = 1; end
    else if (op == 2'b10) begin
      case (fn)
        6'b100010: begin ac = 3'b110; cin = 1; end
        6'b100100: ac = 3'b000;
        6'b100101: ac = 3'b001;
        6'b101010: begin ac = 3'b111; cin = 1; end
        default:   ac = 3'b010;
      endcase
    end
    pe = pcw | (br & z);
    if (r) begin pe = 0; ir = 0; mw = 0; rw = 0; end
    return {pe, io, mw, ir, rd, mtr, rw, sa, sb, ps, ac, cin};
  endfunction

  // One clock cycle: drive, push expectation, compare on negedge, advance model
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic r, input bit chk_cnt);
    exp_t e;
    logic [15:0] got, got4;
    rst    = r;
    opcode = (m_state == 1 || m_state == 2 || m_state == 6) ? op : 6'($urandom);
    funct  = (m_state == 6) ? fn : 6'($urandom);
    zero   = (m_state == 8) ? z : 1'($urandom);
    e.estado  = r ? 4'd0 : 4'(m_state);
    e.ctrl    = exp_ctrl(m_state, fn, zero, r);
    e.cnt     = m_cnt;
    e.cnt4    = m_cnt4;
    e.chk_cnt = chk_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e    = sb_q.pop_front();
      got  = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
              ula_src_a, ula_src_b, pc_src, alu_ctl, ula_cin};
      got4 = {d4_pc_en, d4_iord, d4_mem_write, d4_ir_write, d4_reg_dst, d4_mem_to_reg,
              d4_reg_write, d4_ula_src_a, d4_ula_src_b, d4_pc_src, d4_alu_ctl, d4_ula_cin};
      check("estado", 32'(estado), 32'(e.estado));
      check("ctrl", 32'(got), 32'(e.ctrl));
      check("ctrl_w4", 32'(got4), 32'(e.ctrl));
      check("estado_w4", 32'(d4_estado), 32'(e.estado));
      if (e.chk_cnt) begin
        check("instr_count", instr_count, e.cnt);
        check("instr_count_w4", 32'(d4_instr_count), 32'(e.cnt4));
      end
    end
    @(posedge clk);
    if (r) begin
      m_state = 0;
      m_cnt   = '0;
      m_cnt4  = '0;
    end else begin
      if (m_retire(m_state, opcode)) begin
        m_cnt  = m_cnt + 32'd1;
        m_cnt4 = m_cnt4 + 4'd1;
      end
      m_state = m_next(m_state, opcode);
    end
    #1;
  endtask

  // Run one instruction from FETCH back to FETCH and check its latency
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int exp_lat);
    int cyc;
    cyc = 0;
    do begin
      step(op, fn, z, 1'b0, 1'b1);
      cyc++;
    end while (m_state != 0 && cyc < 20);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    m_state = 0; m_cnt = '0; m_cnt4 = '0;
    @(posedge clk); #1;
    step(6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    step(6'd0, 6'd0, 1'b0, 1'b1, 1'b1);

    run_instr("lw", 6'b100011, 6'd0, 1'b0, 5);
    check("cnt_after_lw", instr_count, 32'd1);
    run_instr("sw", 6'b101011, 6'd0, 1'b0, 4);
    run_instr("r_slt", 6'b000000, 6'b101010, 1'b0, 4);
    check("cnt_after_sw_r", instr_count, 32'd3);
    run_instr("beq_taken", 6'b000100, 6'd0, 1'b1, 3);
    run_instr("beq_not", 6'b000100, 6'd0, 1'b0, 3);
    run_instr("jump", 6'b000010, 6'd0, 1'b0, 3);
    run_instr("unknown", 6'b111111, 6'd0, 1'b0, 2);
    check("cnt_after_unknown", instr_count, 32'd7);
    run_instr("r_add", 6'b000000, 6'b100000, 1'b0, 4);
    run_instr("r_sub", 6'b000000, 6'b100010, 1'b0, 4);
    run_instr("r_and", 6'b000000, 6'b100100, 1'b0, 4);
    run_instr("r_or", 6'b000000, 6'b100101, 1'b0, 4);
    run_instr("r_other", 6'b000000, 6'b100111, 1'b0, 4);
    run_instr("addi", 6'b001000, 6'd0, 1'b0, 4);

    // Counter wrap on the 4-bit instance
    step(6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_instr("addi_wrap", 6'b001000, 6'd0, 1'b0, 4);
    end
    check("wrap_cnt4", 32'(d4_instr_count), 32'd0);
    check("wrap_cnt32", instr_count, 32'd16);

    // Reset mid-instruction, held for two cycles while in EXECUTE
    step(6'b000000, 6'b101010, 1'b0, 1'b0, 1'b1);
    step(6'b000000, 6'b101010, 1'b0, 1'b0, 1'b1);
    check("in_execute", 32'(estado), 32'd6);
    step(6'b000000, 6'b101010, 1'b0, 1'b1, 1'b0);
    step(6'b000000, 6'b101010, 1'b0, 1'b1, 1'b1);
    run_instr("lw_after_rst", 6'b100011, 6'd0, 1'b0, 5);
    check("cnt_after_abort", instr_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
